ats_cmd_collector: RTL and testbench

- Parametrised instruction front-end for the ATS alarm/timer system.
- Deserialises two-word instructions from N clients, each presented on a WORD_W-bit control lane.
- Queues the assembled instructions in a FIFO with a valid/ready drain to the ATS core.
- Generalises the fixed two-client, 16-bit ctrlA/ctrlB request port to any client count, word width and queue depth, and adds back-pressure and protocol-error reporting.

---
 rtl/ats_cmd_collector.sv | 163 ++++++++++++++++
 tb/tb_ats_cmd_collector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ats_cmd_collector.sv
// Two-word instruction collector for N client lanes feeding a valid/ready FIFO to the ATS core.
// Optional build macro: ATS_CMD_OPCODE_FILTER_EN drops opcode 100 words and flags them as protocol errors.
module ats_cmd_collector #(
  parameter int NUM_CLIENTS = 2,
  parameter int WORD_W      = 16,
  parameter int DEPTH       = 4,
  localparam int CLIENT_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic [NUM_CLIENTS*WORD_W-1:0] ctrl,
  output logic                          ready,
  output logic                          proto_err,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [2*WORD_W-1:0]           cmd_data,
  output logic [CLIENT_W-1:0]           cmd_client,
  output logic [LVL_W-1:0]              level,
  output logic [1:0]                    fsm_state
);

  // Handshakes: req is taken only in a cycle where ready=1; the head entry leaves on the
  // rising edge where cmd_valid && cmd_ready; neither side may make valid wait on ready.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WORD2 = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0]      word1_q [NUM_CLIENTS];
  logic [WORD_W-1:0]      word2_q [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] pend_q;
  logic [NUM_CLIENTS-1:0] pend_w1;
  logic                   filt_hit;
  logic                   filt_err_q;

  logic [NUM_CLIENTS-1:0] sel_oh;
  logic [CLIENT_W-1:0]    sel_idx;

  logic accept;
  logic push;
  logic pop;
  logic space_ok;

  logic [2*WORD_W-1:0] mem_data   [DEPTH];
  logic [CLIENT_W-1:0] mem_client [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level_q;

  // Word1 opcode decode per lane: decides which clients carry a real instruction.
  always_comb begin
    pend_w1  = '0;
    filt_hit = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
`ifdef ATS_CMD_OPCODE_FILTER_EN
      pend_w1[i] = (ctrl[i*WORD_W + WORD_W-3 +: 3] != 3'b000) &&
                   (ctrl[i*WORD_W + WORD_W-3 +: 3] != 3'b100);
      if (ctrl[i*WORD_W + WORD_W-3 +: 3] == 3'b100) filt_hit = 1'b1;
`else
      pend_w1[i] = (ctrl[i*WORD_W + WORD_W-3 +: 3] != 3'b000);
`endif
    end
  end

  // Lowest-index pending client wins the single write slot each PUSH cycle.
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx = CLIENT_W'(i);
        sel_oh  = NUM_CLIENTS'(1) << i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WORD2;
      S_WORD2: state_d = (|pend_q) ? S_PUSH : S_IDLE;
      S_PUSH:  if ((pend_q & ~sel_oh) == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Free space of at least one entry per client keeps the PUSH burst from overflowing.
  always_comb begin
    space_ok  = (int'(level_q) <= (DEPTH - NUM_CLIENTS));
    ready     = (state_q == S_IDLE) && space_ok;
    accept    = req && ready;
    push      = (state_q == S_PUSH) && (|pend_q);
    proto_err = (req && !ready) || filt_err_q;
    fsm_state = state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= '0;
      filt_err_q <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        word1_q[i] <= '0;
        word2_q[i] <= '0;
      end
    end else begin
      filt_err_q <= accept && filt_hit;
      if (accept) begin
        pend_q <= pend_w1;
        for (int i = 0; i < NUM_CLIENTS; i++) word1_q[i] <= ctrl[i*WORD_W +: WORD_W];
      end else if (push) begin
        pend_q <= pend_q & ~sel_oh;
      end
      if (state_q == S_WORD2) begin
        for (int i = 0; i < NUM_CLIENTS; i++) word2_q[i] <= ctrl[i*WORD_W +: WORD_W];
      end
    end
  end

  assign pop       = cmd_valid && cmd_ready;
  assign cmd_valid = (level_q != '0);
  assign level     = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]   <= {word1_q[sel_idx], word2_q[sel_idx]};
      mem_client[wr_ptr] <= sel_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head fields read as zero whenever the queue is empty.
  assign cmd_data   = cmd_valid ? mem_data[rd_ptr]   : '0;
  assign cmd_client = cmd_valid ? mem_client[rd_ptr] : '0;

endmodule

// File: tb/tb_ats_cmd_collector.sv
// Directed bench for ats_cmd_collector (default parameters); pops are scored against an expected queue.
module tb_ats_cmd_collector;

  localparam int W = 33;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] ctrl;
  logic        ready;
  logic        proto_err;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [0:0]  cmd_client;
  logic [2:0]  level;
  logic [1:0]  fsm_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  ats_cmd_collector dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ctrl       (ctrl),
    .ready      (ready),
    .proto_err  (proto_err),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_client (cmd_client),
    .level      (level),
    .fsm_state  (fsm_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_pending(input logic [15:0] w);
`ifdef ATS_CMD_OPCODE_FILTER_EN
    return (w[15:13] != 3'b000) && (w[15:13] != 3'b100);
`else
    return (w[15:13] != 3'b000);
`endif
  endfunction

  function automatic logic is_filtered(input logic [15:0] w);
`ifdef ATS_CMD_OPCODE_FILTER_EN
    return (w[15:13] == 3'b100);
`else
    return 1'b0 && (w[15:13] == 3'b100);
`endif
  endfunction

  // Issues one instruction at cycle T; returns at T+2 (#1 after the edge).
  task automatic send(input logic [15:0] a1, input logic [15:0] b1,
                      input logic [15:0] a2, input logic [15:0] b2);
    req  = 1'b1;
    ctrl = {b1, a1};
    if (is_pending(a1)) exp_q.push_back({1'b0, a1, a2});
    if (is_pending(b1)) exp_q.push_back({1'b1, b1, b2});
    step();
    req  = 1'b0;
    ctrl = {b2, a2};
    #1;
    check("t1_ready", ready, 1'b0);
    check("t1_proto_err", proto_err, is_filtered(a1) || is_filtered(b1));
    step();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready; i++) step();
    check("wait_ready", ready, 1'b1);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    repeat (8) step();
    check("drain_level", level, 3'd0);
    check("drain_exp_empty", exp_q.size(), 0);
  endtask

  // scoreboard: every pop must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", {cmd_client, cmd_data}, 33'h0);
      else check("pop_entry", {cmd_client, cmd_data}, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; req = 1'b0; ctrl = '0; cmd_ready = 1'b0;
    repeat (3) step();
    check("rst_ready", ready, 1'b1);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_cmd_data", cmd_data, 32'h0);
    check("rst_cmd_client", cmd_client, 1'b0);
    reset = 1'b1;
    step();

    // two clients, timing of first valid and ready return
    cmd_ready = 1'b1;
    send(16'h2000, 16'h2240, 16'h0000, 16'h0000);
    check("t2_cmd_valid", cmd_valid, 1'b0);
    check("t2_ready", ready, 1'b0);
    step();
    check("t3_cmd_valid", cmd_valid, 1'b1);
    check("t3_client", cmd_client, 1'b0);
    check("t3_data", cmd_data, 32'h20000000);
    step();
    check("t4_ready", ready, 1'b1);
    check("t4_client", cmd_client, 1'b1);
    check("t4_data", cmd_data, 32'h22400000);
    step();
    check("t5_cmd_valid", cmd_valid, 1'b0);

    // only client1 carries an instruction
    wait_ready();
    send(16'h0000, 16'hA00F, 16'h1234, 16'h0045);
    step();
    check("single_level", level, 3'd1);
    check("single_data", cmd_data, 32'hA00F0045);
    step();
    check("single_level_after", level, 3'd0);
    check("single_exp_empty", exp_q.size(), 0);

    // back-pressure fills the queue
    wait_ready();
    cmd_ready = 1'b0;
    send(16'h2001, 16'h4002, 16'h0011, 16'h0022);
    wait_ready();
    send(16'h6003, 16'hE004, 16'h0033, 16'h0044);
    repeat (3) step();
    check("bp_level_full", level, 3'd4);
    check("bp_ready_low", ready, 1'b0);
    req = 1'b1; ctrl = 32'h2AAA2BBB;
    #1;
    check("bp_proto_err", proto_err, 1'b1);
    step();
    req = 1'b0;
    #1;
    check("bp_proto_err_clear", proto_err, 1'b0);
    check("bp_level_hold", level, 3'd4);
    check("bp_state_idle", fsm_state, 2'd0);
    drain();

    // req held through T+1
    wait_ready();
    cmd_ready = 1'b0;
    req = 1'b1; ctrl = {16'h4001, 16'h6002};
    exp_q.push_back({1'b0, 16'h6002, 16'h2222});
    exp_q.push_back({1'b1, 16'h4001, 16'h1111});
    step();
    ctrl = {16'h1111, 16'h2222};
    #1;
    check("held_proto_err", proto_err, 1'b1);
    step();
    req = 1'b0;
    repeat (4) step();
    check("held_level", level, 3'd2);
    drain();

    // reset during an instruction with entries already queued
    wait_ready();
    cmd_ready = 1'b0;
    send(16'h3000, 16'h3001, 16'h0005, 16'h0006);
    repeat (3) step();
    check("mid_level_pre", level, 3'd2);
    check("mid_ready_pre", ready, 1'b1);
    req = 1'b1; ctrl = {16'h5000, 16'h5000};
    step();
    req = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_ready", ready, 1'b1);
    check("mid_level", level, 3'd0);
    check("mid_cmd_valid", cmd_valid, 1'b0);
    check("mid_cmd_data", cmd_data, 32'h0);
    check("mid_cmd_client", cmd_client, 1'b0);
    check("mid_proto_err", proto_err, 1'b0);
    check("mid_state", fsm_state, 2'd0);
    exp_q.delete();
    repeat (2) step();
    reset = 1'b1;
    cmd_ready = 1'b1;
    repeat (5) step();
    check("post_rst_level", level, 3'd0);
    check("post_rst_cmd_valid", cmd_valid, 1'b0);

    // opcode 100 on client0
    wait_ready();
    cmd_ready = 1'b0;
    send(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) step();
`ifdef ATS_CMD_OPCODE_FILTER_EN
    check("op100_level", level, 3'd0);
`else
    check("op100_level", level, 3'd1);
    check("op100_data", cmd_data, 32'h80000000);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
